// File: rtl/argmax_stream_reduce.sv
// argmax_stream_reduce: streaming signed argmax/argmin over fixed-length vectors,
// one element per cycle, registered result with valid/ready on both sides.
module argmax_stream_reduce #(
    parameter int DATA_W  = 32,
    parameter int VEC_LEN = 16,
    parameter int IDX_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_value
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_best_idx;
    logic [DATA_W-1:0] r_best_val;
    logic              r_mode;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_index;
    logic [DATA_W-1:0] r_out_value;
    logic              w_fire;
    logic              w_first;
    logic              w_last;
    logic              w_mode;
    logic              w_better;
    logic              w_take;
    logic [IDX_W-1:0]  w_win_idx;
    logic [DATA_W-1:0] w_win_val;
    assign in_ready  = !r_out_valid || out_ready;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_value = r_out_value;
    assign w_fire    = in_valid && in_ready;
    assign w_first   = r_cnt == '0;
    assign w_last    = r_cnt == LAST_IDX;
    assign w_mode    = w_first ? in_mode : r_mode;
    // strict compare so ties keep the earlier index
    assign w_better  = w_mode ? ($signed(in_data) < $signed(r_best_val))
                              : ($signed(in_data) > $signed(r_best_val));
    assign w_take    = w_first || w_better;
    assign w_win_val = w_take ? in_data : r_best_val;
    assign w_win_idx = w_first ? '0 : (w_better ? r_cnt : r_best_idx);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_value <= '0;
        end else begin
            if (w_fire) begin
                r_best_val <= w_win_val;
                r_best_idx <= w_win_idx;
                r_mode     <= w_mode;
                r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_fire && w_last) begin
                r_out_valid <= 1'b1;
                r_out_index <= w_win_idx;
                r_out_value <= w_win_val;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_argmax_stream_reduce.sv
// tb_argmax_stream_reduce: scoreboard bench for a VEC_LEN=4 and a VEC_LEN=1 instance,
// expected results come from a vector-buffer reference model.
module tb_argmax_stream_reduce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_mode, a_ovalid, a_oready;
    logic [31:0] a_data, a_val;
    logic [1:0]  a_idx;
    logic        b_valid, b_ready, b_mode, b_ovalid, b_oready;
    logic [31:0] b_data, b_val;
    logic [0:0]  b_idx;
    logic        rand_a = 1'b0;
    logic        rand_b = 1'b0;

    argmax_stream_reduce #(.DATA_W(32), .VEC_LEN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_mode(a_mode), .out_valid(a_ovalid), .out_ready(a_oready), .out_index(a_idx),
        .out_value(a_val));
    argmax_stream_reduce #(.DATA_W(32), .VEC_LEN(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_mode(b_mode), .out_valid(b_ovalid), .out_ready(b_oready), .out_index(b_idx),
        .out_value(b_val));

    typedef struct {logic [1:0] idx; logic [31:0] val;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] vbuf[$];
    logic vmode;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // reference: buffer a whole vector, then scan for the first extreme element
    task automatic model_a(input logic [31:0] d, input logic m);
        int b;
        if (vbuf.size() == 0) vmode = m;
        vbuf.push_back(d);
        if (vbuf.size() == 4) begin
            b = 0;
            for (int k = 1; k < 4; k++)
                if (vmode ? ($signed(vbuf[k]) < $signed(vbuf[b])) : ($signed(vbuf[k]) > $signed(vbuf[b])))
                    b = k;
            qa.push_back('{2'(b), vbuf[b]});
            vbuf.delete();
        end
    endtask

    task automatic beat_a(input logic [31:0] d, input logic m);
        bit ok = 0;
        a_valid = 1'b1; a_data = d; a_mode = m;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            if (a_ready) begin ok = 1; model_a(d, m); end
            @(negedge clk);
        end
        a_valid = 1'b0;
        if (!ok) fail_now("a_accept_timeout");
    endtask

    task automatic beat_b(input logic [31:0] d);
        bit ok = 0;
        b_valid = 1'b1; b_data = d; b_mode = 1'($urandom);
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            if (b_ready) begin ok = 1; qb.push_back('{2'b0, d}); end
            @(negedge clk);
        end
        b_valid = 1'b0;
        if (!ok) fail_now("b_accept_timeout");
    endtask

    task automatic expect_a(input string name, input logic v, input logic [1:0] idx, input logic [31:0] val);
        #3;
        check({name, "_valid"}, a_ovalid, v);
        if (v) check({name, "_result"}, {a_idx, a_val}, {idx, val});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
        check("drain_queues_empty", qa.size() + qb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rand_a) a_oready = 1'($urandom);
        if (rand_b) b_oready = 1'($urandom);
    end

    logic hold_a = 1'b0, hold_b = 1'b0;
    logic [33:0] held_a, held_b;
    exp_t ea, eb;
    always @(negedge clk) begin
        #2;
        if (rst_n && hold_a) begin
            check("a_hold_valid", a_ovalid, 1);
            check("a_hold_data", {a_idx, a_val}, held_a);
        end
        if (rst_n && a_ovalid && a_oready) begin
            if (qa.size() == 0) fail_now("a_unexpected_result");
            else begin
                ea = qa.pop_front();
                check("a_scoreboard", {a_idx, a_val}, {ea.idx, ea.val});
            end
        end
        hold_a = rst_n && a_ovalid && !a_oready;
        held_a = {a_idx, a_val};
        if (rst_n && hold_b) begin
            check("b_hold_valid", b_ovalid, 1);
            check("b_hold_data", {b_idx, b_val}, held_b);
        end
        if (rst_n && b_ovalid && b_oready) begin
            if (qb.size() == 0) fail_now("b_unexpected_result");
            else begin
                eb = qb.pop_front();
                check("b_scoreboard", {b_idx, b_val}, {eb.idx[0], eb.val});
            end
        end
        hold_b = rst_n && b_ovalid && !b_oready;
        held_b = {b_idx, b_val};
    end

    initial begin
        #900000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 0; a_data = 0; a_mode = 0; a_oready = 1;
        b_valid = 0; b_data = 0; b_mode = 0; b_oready = 1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_a_out", {a_ovalid, a_idx, a_val}, 0);
        check("reset_a_ready", a_ready, 1);
        check("reset_b_out", {b_ovalid, b_idx, b_val}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        beat_a(3, 0); beat_a(9, 0); beat_a(-32'sd2, 0); beat_a(7, 0);
        expect_a("basic", 1, 1, 9);
        expect_a("basic_one_cycle", 0, 0, 0);

        beat_a(-32'sd5, 0); beat_a(-32'sd1, 0); beat_a(-32'sd1, 0); beat_a(-32'sd8, 0);
        expect_a("tie_signed", 1, 1, -32'sd1);

        beat_a(4, 1); beat_a(32'h8000_0000, 0); beat_a(0, 0); beat_a(5, 0);
        expect_a("argmin", 1, 1, 32'h8000_0000);
        beat_a(4, 0); beat_a(32'h8000_0000, 1); beat_a(0, 1); beat_a(5, 1);
        expect_a("argmax_revert", 1, 3, 5);

        a_oready = 1'b0;
        beat_a(10, 0); beat_a(20, 0); beat_a(30, 0); beat_a(40, 0);
        fork
            begin
                beat_a(5, 1); beat_a(-32'sd3, 1); beat_a(8, 1); beat_a(1, 1);
            end
            begin
                repeat (5) begin
                    #3;
                    check("bp_in_ready_low", a_ready, 0);
                    check("bp_result_held", {a_ovalid, a_idx, a_val}, {1'b1, 2'd3, 32'd40});
                    @(negedge clk);
                end
                a_oready = 1'b1;
            end
        join
        drain();

        beat_a(100, 0); beat_a(200, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_out", {a_ovalid, a_idx, a_val}, 0);
        check("midreset_ready", a_ready, 1);
        vbuf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat_a(1, 0); beat_a(2, 0); beat_a(3, 0); beat_a(0, 0);
        expect_a("after_reset", 1, 2, 3);

        rand_a = 1'b1;
        for (int v = 0; v < 60; v++)
            for (int k = 0; k < 4; k++)
                beat_a(($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom,
                       1'($urandom));
        rand_a = 1'b0;
        a_oready = 1'b1;
        drain();

        rand_b = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            beat_b($urandom);
        end
        rand_b = 1'b0;
        b_oready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
